// File: rtl/and_operand_stager.sv
// and_operand_stager: pairs operand beats from a shared bus into A/B registers
// and presents each completed pair to the downstream AND gate with a
// valid/ready handshake. Flags framing errors and counts delivered pairs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD_A   | waiting for a first-marked beat to capture as operand A
// LOAD_B   | A captured; waiting for the B beat (a first-marked beat resyncs A)
// PRESENT  | a_out/b_out hold a complete pair; waiting for pair_ready
module and_operand_stager #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_first,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic                 sync_err,
  output logic [CNT_WIDTH-1:0] pair_count
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 sync_err_q, sync_err_d;
  logic [CNT_WIDTH-1:0] pair_count_q, pair_count_d;
  logic                 accept;

  // Handshake outputs are pure state decodes so no input reaches them combinationally.
  assign in_ready   = (state_q != PRESENT);
  assign pair_valid = (state_q == PRESENT);
  assign accept     = in_valid & in_ready;

  // Next-state and datapath decisions for each state.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sync_err_d   = 1'b0;
    pair_count_d = pair_count_q;
    unique case (state_q)
      LOAD_A: begin
        if (accept) begin
          if (in_first) begin
            a_d     = in_data;
            state_d = LOAD_B;
          end else begin
            // Orphan B beat: dropped, only the error is reported.
            sync_err_d = 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (in_first) begin
            // New frame started before B arrived: replace the stale A.
            a_d        = in_data;
            sync_err_d = 1'b1;
          end else begin
            b_d     = in_data;
            state_d = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (pair_ready) begin
          pair_count_d = pair_count_q + 1'b1;
          state_d      = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD_A;
      a_q          <= '0;
      b_q          <= '0;
      sync_err_q   <= 1'b0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sync_err_q   <= sync_err_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign sync_err   = sync_err_q;
  assign pair_count = pair_count_q;

endmodule

// File: tb/tb_and_operand_stager.sv
// Bench for and_operand_stager: directed scenarios with literal expectations
// plus a randomized run, all cross-checked every cycle against a pairing model.
module tb_and_operand_stager;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MOD   = 1 << CNT_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [WIDTH-1:0]     in_data;
  logic                 in_first;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a_out;
  logic [WIDTH-1:0]     b_out;
  logic                 pair_valid;
  logic                 pair_ready;
  logic                 sync_err;
  logic [CNT_WIDTH-1:0] pair_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  and_operand_stager #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_first   (in_first),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_out      (a_out),
    .b_out      (b_out),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .sync_err   (sync_err),
    .pair_count (pair_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending-A flag, a full-pair flag, the held operands and
  // a pair tally. It only looks at the bench's own inputs.
  logic           m_have_a, m_full, m_err;
  logic [WIDTH-1:0] m_a, m_b;
  int             m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have_a = 1'b0; m_full = 1'b0; m_err = 1'b0;
      m_a = '0; m_b = '0; m_cnt = 0;
    end else begin
      m_err = 1'b0;
      if (m_full) begin
        if (pair_ready) begin
          m_full = 1'b0;
          m_cnt  = (m_cnt + 1) % CNT_MOD;
        end
      end else if (in_valid) begin
        if (in_first) begin
          m_err    = m_have_a;
          m_a      = in_data;
          m_have_a = 1'b1;
        end else if (m_have_a) begin
          m_b      = in_data;
          m_have_a = 1'b0;
          m_full   = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  // Every falling edge the DUT must agree with the model.
  always @(negedge clk) begin
    chk("cmp_in_ready",   32'(in_ready),   32'(!m_full));
    chk("cmp_pair_valid", 32'(pair_valid), 32'(m_full));
    chk("cmp_a_out",      32'(a_out),      32'(m_a));
    chk("cmp_b_out",      32'(b_out),      32'(m_b));
    chk("cmp_sync_err",   32'(sync_err),   32'(m_err));
    chk("cmp_pair_count", 32'(pair_count), 32'(m_cnt));
  end

  // Drives one beat and returns 1 ns after the edge that accepted it.
  task automatic beat(input logic [WIDTH-1:0] d, input logic f);
    logic r;
    bit   done = 0;
    in_valid = 1'b1; in_data = d; in_first = f;
    for (int i = 0; i < 50 && !done; i++) begin
      r = in_ready;
      @(posedge clk); #1;
      done = r;
    end
    if (!done) chk("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  int last_b_cyc;

  initial begin
    rst_n = 1'b0; in_data = '0; in_first = 1'b0; in_valid = 1'b0; pair_ready = 1'b0;
    #1;
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_pair_valid", 32'(pair_valid), 32'd0);
    chk("rst_a_out",      32'(a_out),      32'd0);
    chk("rst_pair_count", 32'(pair_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Basic pair
    pair_ready = 1'b1;
    beat(8'hF0, 1'b1);
    beat(8'h3C, 1'b0);
    chk("basic_pair_valid", 32'(pair_valid), 32'd1);
    chk("basic_a",          32'(a_out), 32'hF0);
    chk("basic_b",          32'(b_out), 32'h3C);
    chk("basic_and",        32'(a_out & b_out), 32'h30);
    tick();
    chk("basic_count",      32'(pair_count), 32'd1);
    chk("basic_valid_drop", 32'(pair_valid), 32'd0);

    // Backpressure
    pair_ready = 1'b0;
    beat(8'hA5, 1'b1);
    beat(8'h5A, 1'b0);
    in_valid = 1'b1; in_data = 8'h77; in_first = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(pair_valid), 32'd1);
      chk("bp_ready", 32'(in_ready),   32'd0);
      chk("bp_a",     32'(a_out),      32'hA5);
      chk("bp_b",     32'(b_out),      32'h5A);
    end
    pair_ready = 1'b1;
    tick();
    chk("bp_handoff_ready", 32'(in_ready), 32'd1);
    chk("bp_handoff_count", 32'(pair_count), 32'd2);
    tick();
    chk("bp_held_beat_a", 32'(a_out), 32'h77);
    in_valid = 1'b0;
    beat(8'h00, 1'b0);
    tick();

    // Resync
    beat(8'h11, 1'b1);
    chk("rs_no_err_first", 32'(sync_err), 32'd0);
    beat(8'h22, 1'b1);
    chk("rs_err", 32'(sync_err), 32'd1);
    chk("rs_a",   32'(a_out), 32'h22);
    beat(8'hFF, 1'b0);
    chk("rs_err_clear", 32'(sync_err), 32'd0);
    chk("rs_pair_a", 32'(a_out), 32'h22);
    chk("rs_pair_b", 32'(b_out), 32'hFF);
    tick();

    // Orphan B straight after reset
    do_reset();
    beat(8'h55, 1'b0);
    chk("orphan_err",   32'(sync_err), 32'd1);
    chk("orphan_a",     32'(a_out),    32'd0);
    chk("orphan_ready", 32'(in_ready), 32'd1);
    tick();
    chk("orphan_err_one_cycle", 32'(sync_err), 32'd0);

    // Counter wrap over 17 back-to-back pairs
    pair_ready = 1'b1;
    last_b_cyc = -1;
    for (int i = 0; i < 17; i++) begin
      beat(8'(i + 1), 1'b1);
      beat(8'(8'hC0 + i), 1'b0);
      if (last_b_cyc >= 0) chk("wrap_period", 32'(cyc - last_b_cyc), 32'd3);
      last_b_cyc = cyc;
      if (i == 16) begin
        tick();
        chk("wrap_count_17", 32'(pair_count), 32'd1);
      end else if (i == 15) begin
        in_valid = 1'b0;
      end
    end
    chk("wrap_count_15", 32'(CNT_MOD - 1), 32'd15);

    // Async reset while in LOAD_B
    beat(8'h9C, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_a",     32'(a_out),      32'd0);
    chk("ar_b",     32'(b_out),      32'd0);
    chk("ar_count", 32'(pair_count), 32'd0);
    chk("ar_valid", 32'(pair_valid), 32'd0);
    chk("ar_ready", 32'(in_ready),   32'd1);
    tick();
    rst_n = 1'b1;
    beat(8'h44, 1'b0);
    chk("ar_orphan_err", 32'(sync_err), 32'd1);

    // Random traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_first   = ($urandom_range(0, 2) == 0);
      in_data    = 8'($urandom);
      pair_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/and_operand_stager.md
# and_operand_stager

- Upstream feeder for the team's parameterized WIDTH-bit AND gate.
- Accepts operands one beat at a time on a shared WIDTH-bit bus with a valid/ready handshake, and pairs them as A then B.
- Presents each completed pair as stable `a_out`/`b_out` with a valid/ready handshake to the gate's consumer.
- Detects framing errors via a first-beat marker, and keeps a wrapping count of delivered pairs.

## Interface
- `WIDTH`, default 8: width of each operand and of the data bus.
- `CNT_WIDTH`, default 16: width of `pair_count`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clk` in the integrating design.
- `in_data`  in  WIDTH  operand beat.
- `in_first`  in  1  marks the beat as operand A of a new pair.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  stager can accept a beat.
- `a_out`  out  WIDTH  staged operand A; drives the gate's `a`.
- `b_out`  out  WIDTH  staged operand B; drives the gate's `b`.
- `pair_valid`  out  1  `a_out`/`b_out` form a complete pair.
- `pair_ready`  in  1  consumer has taken the pair.
- `sync_err`  out  1  one-cycle pulse on a framing error.
- `pair_count`  out  CNT_WIDTH  number of pairs delivered, modulo 2^CNT_WIDTH.

## Operation
- A beat is accepted on a rising edge where `in_valid & in_ready`.
- FSM states are LOAD_A, LOAD_B and PRESENT. Reset state is LOAD_A.
- **LOAD_A:**
  - Accepted beat with `in_first=1`: `a_out <= in_data`, go to LOAD_B.
  - Accepted beat with `in_first=0`: drop the beat, pulse `sync_err`, stay in LOAD_A.
- **LOAD_B:**
  - Accepted beat with `in_first=0`: `b_out <= in_data`, go to PRESENT.
  - Accepted beat with `in_first=1`: resync. `a_out <= in_data`, pulse `sync_err`, stay in LOAD_B. The old A is discarded.
- **PRESENT:**
  - `pair_valid=1`.
  - When `pair_valid & pair_ready`: `pair_count <= pair_count + 1` (wraps from all-ones to 0), go to LOAD_A.
- `in_ready` is decoded from state only: 1 in LOAD_A and LOAD_B, 0 in PRESENT.
- `pair_valid` is decoded from state only: 1 only in PRESENT.
- Neither depends combinationally on any input.
- `a_out` and `b_out` are registers:
  - Stable throughout PRESENT.
  - Hold their last values after handoff until overwritten by a new accepted beat.
  - `b_out` may therefore be stale while in LOAD_A/LOAD_B. Consumers qualify with `pair_valid`.
- `sync_err` is a registered pulse, high for exactly the cycle after the offending accepted beat. Back-to-back errors give back-to-back high cycles.
- Beats presented while `in_ready=0` are not consumed and have no effect. The upstream must hold them.

## Timing
- All outputs reset to 0 and the FSM resets to LOAD_A: `in_ready` is 1 from reset, `a_out`, `b_out`, `pair_count`, `sync_err` and `pair_valid` are 0.
- Latency: the B beat accepted at edge N gives `pair_valid=1` in the cycle after edge N.
- Handoff at edge M (`pair_valid & pair_ready`) gives `in_ready=1` and `pair_valid=0` after edge M.
- Minimum of 3 cycles per pair: A, B, then 1 PRESENT cycle when `pair_ready` is held high.
- `pair_ready` may be high before `pair_valid`. It has no effect outside PRESENT.
- `pair_count` updates on the same edge as the handoff.
- Reset asserted mid-pair (any state): partial operands are lost, the FSM returns to LOAD_A, and the count is cleared. The first beat after reset must carry `in_first=1`.
- `in_valid` with unknown `in_first` is illegal only when `in_ready=1`.

## Test plan
- **Basic pair (WIDTH=8):** send A=0xF0 (`in_first=1`), then B=0x3C, with `pair_ready=1`. Expect `pair_valid` high for 1 cycle with `a_out=0xF0`, `b_out=0x3C`, `pair_count=1`. The downstream gate output is 0x30.
- **Backpressure:** complete a pair and hold `pair_ready=0` for 5 cycles while driving `in_valid=1` with new data. Expect `pair_valid`, `a_out` and `b_out` stable for all 5 cycles, `in_ready=0`, and no beat consumed. Release `pair_ready`: the held beat is accepted the cycle after handoff.
- **Resync:** send A=0x11, then A=0x22 (both `in_first=1`), then B=0xFF. Expect `sync_err` high for exactly 1 cycle after the second A, and a pair with `a_out=0x22`, `b_out=0xFF`.
- **Orphan B:** from LOAD_A, send a beat with `in_first=0`, data 0x55. Expect `sync_err` pulse, no state change, and `a_out` unchanged at 0.
- **Counter wrap (CNT_WIDTH=4):** deliver 17 pairs back-to-back. Expect `pair_count` sequence 1..15, 0, 1, and a 3-cycle pair period.
- **Async reset mid-pair:** assert `rst_n=0` between clock edges while in LOAD_B. Expect all outputs 0 immediately, `in_ready=1` after release, and the next B-only beat to raise `sync_err`.
